cavlc_block_scan: RTL and testbench

CAVLC_BLOCK_SCAN -- requirements
Module: cavlc_block_scan

---
 rtl/cavlc_pkg.sv | 30 +++
 rtl/cavlc_coeff_classify.sv | 21 ++
 rtl/cavlc_block_scan.sv | 129 ++++++++++++
 tb/tb_cavlc_block_scan.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cavlc_pkg.sv
// cavlc_pkg -- shared constants, FSM encoding and helpers for the CAVLC block scanner.
// Rev 1.0
`default_nettype none

package cavlc_pkg;

  localparam int BLK_COEFFS = 16;
  localparam int COEFF_W    = 12;
  localparam int MAX_T1     = 3;
  localparam int IDX_W      = $clog2(BLK_COEFFS);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Only the lowest 'run' sign bits belong to real trailing ones.
  function automatic logic [2:0] t1_mask(input logic [1:0] run);
    case (run)
      2'd0:    t1_mask = 3'b000;
      2'd1:    t1_mask = 3'b001;
      2'd2:    t1_mask = 3'b011;
      default: t1_mask = 3'b111;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/cavlc_coeff_classify.sv
// cavlc_coeff_classify -- combinational nonzero / +-1 / sign decode of one coefficient.
// Rev 1.0
`default_nettype none

module cavlc_coeff_classify
  import cavlc_pkg::*;
(
  input  logic [COEFF_W-1:0] coeff,
  output logic               nonzero,
  output logic               is_one,
  output logic               sign
);

  // -2048 (only the MSB set) is nonzero and never matches +-1.
  assign nonzero = |coeff;
  assign is_one  = (coeff == COEFF_W'(1)) || (coeff == {COEFF_W{1'b1}});
  assign sign    = coeff[COEFF_W-1];

endmodule

`default_nettype wire

// File: rtl/cavlc_block_scan.sv
// cavlc_block_scan -- gathers TotalCoeff/TrailingOnes/total_zeros over a 4x4 block
// and hands the statistics to the coeff-token encoder. Rev 1.0
`default_nettype none

module cavlc_block_scan
  import cavlc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               coeff_valid,
  input  logic [COEFF_W-1:0] coeff_in,
  input  logic [3:0]         nc_in,
  output logic               coeff_ready,
  output logic [3:0]         nC,
  output logic [4:0]         NZQs,
  output logic [1:0]         T1,
  output logic [3:0]         total_zeros,
  output logic [2:0]         t1_signs,
  output logic               start_coeff_token,
  input  logic               finish_coeff_token,
  output logic               blk_done
);

  state_t state, state_nx;

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] last_idx;
  logic [2:0]       signs;
  logic             nonzero, is_one, sign;
  logic             accept;
  logic             release_blk;

  logic [4:0]       nz_nx;
  logic [1:0]       run_nx;
  logic [2:0]       signs_nx;
  logic [IDX_W-1:0] last_nx;
  logic [3:0]       tz_nx;

  cavlc_coeff_classify u_classify (
    .coeff   (coeff_in),
    .nonzero (nonzero),
    .is_one  (is_one),
    .sign    (sign)
  );

  assign accept      = coeff_valid && (state == COLLECT);
  assign release_blk = (state == ISSUE) && finish_coeff_token;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= COLLECT;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx          = state;
    coeff_ready       = 1'b0;
    start_coeff_token = 1'b0;
    blk_done          = 1'b0;
    case (state)
      COLLECT: begin
        coeff_ready = 1'b1;
        if (accept && (idx == IDX_W'(BLK_COEFFS - 1))) state_nx = ISSUE;
      end
      ISSUE: begin
        start_coeff_token = 1'b1;
        if (finish_coeff_token) state_nx = RELEASE;
      end
      RELEASE: begin
        blk_done = 1'b1;
        state_nx = COLLECT;
      end
      default: state_nx = COLLECT;
    endcase
  end

  // The T1 output register doubles as the saturating trailing-ones run.
  always_comb begin
    nz_nx    = NZQs;
    run_nx   = T1;
    signs_nx = signs;
    last_nx  = last_idx;
    if (nonzero) begin
      nz_nx   = NZQs + 5'd1;
      last_nx = idx;
      if (is_one) begin
        run_nx   = (T1 == 2'(MAX_T1)) ? T1 : T1 + 2'd1;
        signs_nx = {signs[1:0], sign};
      end else begin
        run_nx = 2'd0;
      end
    end
    // Result always fits 0..15, so modulo-16 arithmetic is exact (covers NZQs = 16).
    tz_nx = (nz_nx == 5'd0) ? 4'd0 : (last_nx + 4'd1 - nz_nx[3:0]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx         <= '0;
      last_idx    <= '0;
      signs       <= '0;
      nC          <= '0;
      NZQs        <= '0;
      T1          <= '0;
      total_zeros <= '0;
      t1_signs    <= '0;
    end else if (release_blk) begin
      idx         <= '0;
      last_idx    <= '0;
      signs       <= '0;
      nC          <= '0;
      NZQs        <= '0;
      T1          <= '0;
      total_zeros <= '0;
      t1_signs    <= '0;
    end else if (accept) begin
      idx         <= idx + IDX_W'(1);
      last_idx    <= last_nx;
      signs       <= signs_nx;
      NZQs        <= nz_nx;
      T1          <= run_nx;
      total_zeros <= tz_nx;
      t1_signs    <= signs_nx & t1_mask(run_nx);
      if (idx == '0) nC <= nc_in;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cavlc_block_scan.sv
// tb_cavlc_block_scan -- scoreboard bench for the CAVLC block scanner.
// Rev 1.0
`default_nettype none

module tb_cavlc_block_scan;

  typedef struct packed {
    logic [4:0] nz;
    logic [1:0] t1;
    logic [3:0] tz;
    logic [2:0] sg;
    logic [3:0] nc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        coeff_valid;
  logic [11:0] coeff_in;
  logic [3:0]  nc_in;
  logic        coeff_ready;
  logic [3:0]  nC;
  logic [4:0]  NZQs;
  logic [1:0]  T1;
  logic [3:0]  total_zeros;
  logic [2:0]  t1_signs;
  logic        start_coeff_token;
  logic        finish_coeff_token;
  logic        blk_done;

  int checks   = 0;
  int failures = 0;

  logic signed [11:0] blk [16];
  exp_t sb [$];

  cavlc_block_scan dut (
    .clk                (clk),
    .rst                (rst),
    .coeff_valid        (coeff_valid),
    .coeff_in           (coeff_in),
    .nc_in              (nc_in),
    .coeff_ready        (coeff_ready),
    .nC                 (nC),
    .NZQs               (NZQs),
    .T1                 (T1),
    .total_zeros        (total_zeros),
    .t1_signs           (t1_signs),
    .start_coeff_token  (start_coeff_token),
    .finish_coeff_token (finish_coeff_token),
    .blk_done           (blk_done)
  );

  always #5 clk = ~clk;

  // Reference: scan from the high-frequency end for trailing ones.
  function automatic exp_t model(input logic [3:0] nc);
    exp_t e;
    int nz, last, t1;
    logic [2:0] sg;
    nz = 0; last = 0; t1 = 0; sg = 3'b000;
    for (int i = 0; i < 16; i++)
      if (blk[i] != 0) begin nz++; last = i; end
    for (int i = 15; i >= 0; i--) begin
      if (t1 == 3) break;
      if (blk[i] != 0) begin
        if (blk[i] == 1 || blk[i] == -1) begin
          sg[t1] = (blk[i] < 0);
          t1++;
        end else break;
      end
    end
    e.nz = 5'(nz);
    e.t1 = 2'(t1);
    e.tz = (nz == 0) ? 4'd0 : 4'(last + 1 - nz);
    e.sg = sg;
    e.nc = nc;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic [3:0] nc, input bit gaps, input bit hold_valid);
    sb.push_back(model(nc));
    for (int i = 0; i < 16; i++) begin
      if (gaps && i > 0) begin
        int g;
        g = $urandom_range(1, 3);
        for (int k = 0; k < g; k++) begin
          coeff_valid = 1'b0;
          coeff_in    = 12'h7FF;
          nc_in       = ~nc;
          tick();
        end
      end
      coeff_valid = 1'b1;
      coeff_in    = blk[i];
      nc_in       = (i == 0) ? nc : ~nc;
      tick();
    end
    if (!hold_valid) coeff_valid = 1'b0;
  endtask

  task automatic check_issue(input string name, input int delay);
    int n;
    exp_t e;
    n = 0;
    while (start_coeff_token !== 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (start_coeff_token !== 1'b1) begin
      failures++;
      $display("FAIL %s start_timeout: start=%b want 1", name, start_coeff_token);
      return;
    end
    checks++;
    if (n !== 0) begin
      failures++;
      $display("FAIL %s start_latency: waited %0d cycles want 0", name, n);
    end
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard_empty: size=0 want >0", name);
      return;
    end
    e = sb.pop_front();
    checks++;
    if ({NZQs, T1, total_zeros, t1_signs, nC} !== e) begin
      failures++;
      $display("FAIL %s stats: NZQs=%0d T1=%0d tz=%0d signs=%b nC=%0d want NZQs=%0d T1=%0d tz=%0d signs=%b nC=%0d",
               name, NZQs, T1, total_zeros, t1_signs, nC, e.nz, e.t1, e.tz, e.sg, e.nc);
    end
    for (int d = 0; d < delay; d++) begin
      finish_coeff_token = 1'b0;
      tick();
      checks++;
      if ({start_coeff_token, coeff_ready, blk_done} !== 3'b100 ||
          {NZQs, T1, total_zeros, t1_signs, nC} !== e) begin
        failures++;
        $display("FAIL %s issue_hold[%0d]: start=%b ready=%b done=%b stats=%h want 1/0/0 stats=%h",
                 name, d, start_coeff_token, coeff_ready, blk_done,
                 {NZQs, T1, total_zeros, t1_signs, nC}, e);
      end
    end
    finish_coeff_token = 1'b1;
    tick();
    finish_coeff_token = 1'b0;
    checks++;
    if ({blk_done, start_coeff_token, coeff_ready} !== 3'b100) begin
      failures++;
      $display("FAIL %s release: done=%b start=%b ready=%b want 1/0/0",
               name, blk_done, start_coeff_token, coeff_ready);
    end
    checks++;
    if ({NZQs, T1, total_zeros, t1_signs, nC} !== '0) begin
      failures++;
      $display("FAIL %s cleared: stats=%h want 0", name, {NZQs, T1, total_zeros, t1_signs, nC});
    end
    coeff_valid = 1'b0;
    tick();
    checks++;
    if ({blk_done, coeff_ready} !== 2'b01) begin
      failures++;
      $display("FAIL %s back_to_collect: done=%b ready=%b want 0/1", name, blk_done, coeff_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    coeff_valid = 1'b0;
    coeff_in = '0;
    nc_in = '0;
    finish_coeff_token = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({coeff_ready, start_coeff_token, blk_done} !== 3'b100 ||
        {NZQs, T1, total_zeros, t1_signs, nC} !== '0) begin
      failures++;
      $display("FAIL reset_state: ready=%b start=%b done=%b stats=%h want 1/0/0 stats=0",
               coeff_ready, start_coeff_token, blk_done, {NZQs, T1, total_zeros, t1_signs, nC});
    end
  endtask

  task automatic test_directed();
    blk = '{0, 3, 0, 1, -1, -1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    send_block(4'd2, 1'b0, 1'b0);
    check_issue("zigzag", 0);
    for (int i = 0; i < 16; i++) blk[i] = 0;
    send_block(4'd5, 1'b0, 1'b0);
    check_issue("all_zero", 0);
    for (int i = 0; i < 16; i++) blk[i] = 1;
    send_block(4'd7, 1'b0, 1'b0);
    check_issue("all_plus1", 0);
    for (int i = 0; i < 16; i++) blk[i] = 0;
    blk[15] = 5;
    send_block(4'd0, 1'b0, 1'b0);
    check_issue("five_at_15", 0);
    blk = '{1, -1, 0, -2048, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    send_block(4'd15, 1'b0, 1'b0);
    check_issue("min_value", 0);
  endtask

  task automatic test_delayed_finish();
    blk = '{-1, 2, 0, 0, 1, 0, -1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    send_block(4'd9, 1'b0, 1'b1);
    check_issue("delayed_finish", 10);
    blk = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1};
    send_block(4'd3, 1'b0, 1'b0);
    check_issue("after_delay", 0);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 7; i++) begin
      coeff_valid = 1'b1;
      coeff_in = 12'd3;
      nc_in = 4'd11;
      tick();
    end
    coeff_valid = 1'b0;
    rst = 1'b0;
    #2;
    checks++;
    if ({NZQs, T1, total_zeros, t1_signs, nC} !== '0 || {start_coeff_token, blk_done} !== 2'b00) begin
      failures++;
      $display("FAIL mid_reset_clear: stats=%h start=%b done=%b want 0",
               {NZQs, T1, total_zeros, t1_signs, nC}, start_coeff_token, blk_done);
    end
    tick();
    rst = 1'b1;
    blk = '{1, 1, -1, 0, 0, 4, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    send_block(4'd6, 1'b0, 1'b0);
    check_issue("fresh_after_reset", 0);
    for (int i = 0; i < 16; i++) blk[i] = 1;
    send_block(4'd1, 1'b0, 1'b0);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    void'(sb.pop_front());
    for (int d = 0; d < 4; d++) begin
      tick();
      checks++;
      if ({blk_done, start_coeff_token, coeff_ready} !== 3'b001) begin
        failures++;
        $display("FAIL issue_reset[%0d]: done=%b start=%b ready=%b want 0/0/1",
                 d, blk_done, start_coeff_token, coeff_ready);
      end
    end
  endtask

  task automatic test_gaps();
    blk = '{0, 3, 0, 1, -1, -1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    send_block(4'd2, 1'b1, 1'b0);
    check_issue("gapped_zigzag", 0);
  endtask

  task automatic test_finish_ignored();
    logic signed [11:0] pool [6];
    pool = '{0, 1, -1, 2, -2, -2048};
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) blk[i] = pool[$urandom_range(0, 5)];
      finish_coeff_token = 1'b1;
      send_block(4'($urandom_range(0, 15)), r[0], 1'b0);
      finish_coeff_token = 1'b0;
      check_issue("random_finish_in_collect", r);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_delayed_finish();
    test_mid_reset();
    test_gaps();
    test_finish_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
